// File: rtl/mult_bus_master_if.sv
// Operand/result streams and peripheral register bus of the multiplier sequencer.
// master = sequencer side, slave = host/peripheral side.
interface mult_bus_master_if;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_a;
   logic [23:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_product;
   logic [23:0] out_ones;
   logic        out_timeout;
   logic        out_mismatch;
   logic [15:0] saddress;
   logic        swr;
   logic        srd;
   logic [31:0] sdata_out;
   logic [31:0] sdata_in;
   logic        busy;

   modport master (
      input  in_valid, in_a, in_b, out_ready, sdata_in,
      output in_ready, out_valid, out_product, out_ones,
      output out_timeout, out_mismatch,
      output saddress, swr, srd, sdata_out, busy
   );

   modport slave (
      output in_valid, in_a, in_b, out_ready, sdata_in,
      input  in_ready, out_valid, out_product, out_ones,
      input  out_timeout, out_mismatch,
      input  saddress, swr, srd, sdata_out, busy
   );
endinterface

// File: rtl/mult_bus_master.sv
// Bus sequencer driving the GPIO multiplier peripheral.
// Writes operands, starts, polls status, reads product and ones count.
module mult_bus_master #(
   parameter int POLL_MAX = 64
) (
   input logic            clk,
   input logic            reset,
   mult_bus_master_if.master bus
);

   localparam logic [7:0] PMAX = 8'(POLL_MAX);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_RD_STAT,
      S_EVAL, S_RD_RES, S_RD_ONES, S_CHECK, S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [7:0]  poll_q, poll_d;
   logic [23:0] a_q, a_d, b_q, b_d;
   logic [1:0]  stat_q;
   logic [31:0] prod_q;
   logic [23:0] ones_q;
   logic [5:0]  pop;

   logic        in_ready_q, busy_q, out_valid_q;
   logic [15:0] saddr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        swr_q, srd_q, is_wr, is_rd;
   logic [31:0] prod_o;
   logic [23:0] ones_o;
   logic        to_o, mm_o;

   function automatic state_t next_acc(input state_t s);
      unique case (s)
         S_WR_A1:   return S_WR_A2;
         S_WR_A2:   return S_WR_GO;
         S_WR_GO:   return S_RD_STAT;
         S_RD_STAT: return S_EVAL;
         S_RD_RES:  return S_RD_ONES;
         S_RD_ONES: return S_CHECK;
         default:   return S_IDLE;
      endcase
   endfunction

   // Next state, access phase, poll count and operand latch
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      poll_d  = poll_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               poll_d  = 8'd0;
               phase_d = 2'd0;
               state_d = S_WR_A1;
            end
         end
         S_WR_A1, S_WR_A2, S_WR_GO,
         S_RD_STAT, S_RD_RES, S_RD_ONES: begin
            if (phase_q == 2'd2) begin
               phase_d = 2'd0;
               state_d = next_acc(state_q);
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         S_EVAL: begin
            if (stat_q == 2'b11) begin
               state_d = S_RD_RES;
            end else if (poll_q == PMAX) begin
               state_d = S_RESP;
            end else begin
               poll_d  = (poll_q == 8'hFF) ? poll_q : poll_q + 8'd1;
               state_d = S_RD_STAT;
            end
         end
         S_CHECK: state_d = S_RESP;
         S_RESP:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Address, write data and strobe kind for the upcoming access
   always_comb begin
      addr_d  = 16'h0000;
      wdata_d = 32'h0;
      is_wr   = 1'b0;
      is_rd   = 1'b0;
      unique case (state_d)
         S_WR_A1: begin
            addr_d  = 16'h037F;
            wdata_d = {8'h00, a_d};
            is_wr   = 1'b1;
         end
         S_WR_A2: begin
            addr_d  = 16'h0388;
            wdata_d = {8'h00, b_d};
            is_wr   = 1'b1;
         end
         S_WR_GO: begin
            addr_d = 16'h03A0;
            is_wr  = 1'b1;
         end
         S_RD_STAT: begin
            addr_d = 16'h03A0;
            is_rd  = 1'b1;
         end
         S_RD_RES: begin
            addr_d = 16'h0390;
            is_rd  = 1'b1;
         end
         S_RD_ONES: begin
            addr_d = 16'h0398;
            is_rd  = 1'b1;
         end
         default: ;
      endcase
   end

   // Popcount of the captured product
   always_comb begin
      pop = 6'd0;
      for (int i = 0; i < 32; i++) pop = pop + {5'd0, prod_q[i]};
   end

   // Control state and registered bus/handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         phase_q     <= 2'd0;
         poll_q      <= 8'd0;
         a_q         <= 24'd0;
         b_q         <= 24'd0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         saddr_q     <= 16'h0000;
         wdata_q     <= 32'h0;
         swr_q       <= 1'b0;
         srd_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         poll_q      <= poll_d;
         a_q         <= a_d;
         b_q         <= b_d;
         in_ready_q  <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         out_valid_q <= (state_d == S_RESP);
         saddr_q     <= addr_d;
         wdata_q     <= wdata_d;
         swr_q       <= is_wr && (phase_d == 2'd1);
         srd_q       <= is_rd && (phase_d == 2'd1);
      end
   end

   // Read captures at end of HOLD and result registers loaded on entry to RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_q <= 2'b00;
         prod_q <= 32'h0;
         ones_q <= 24'd0;
         prod_o <= 32'h0;
         ones_o <= 24'd0;
         to_o   <= 1'b0;
         mm_o   <= 1'b0;
      end else begin
         if (phase_q == 2'd2) begin
            if (state_q == S_RD_STAT) stat_q <= bus.sdata_in[1:0];
            if (state_q == S_RD_RES)  prod_q <= bus.sdata_in;
            if (state_q == S_RD_ONES) ones_q <= bus.sdata_in[23:0];
         end
         if (state_q == S_CHECK) begin
            prod_o <= prod_q;
            ones_o <= ones_q;
            to_o   <= 1'b0;
            mm_o   <= ({18'd0, pop} != ones_q);
         end else if (state_q == S_EVAL && state_d == S_RESP) begin
            prod_o <= 32'h0;
            ones_o <= 24'd0;
            to_o   <= 1'b1;
            mm_o   <= 1'b0;
         end
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.busy         = busy_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.saddress     = saddr_q;
   assign bus.sdata_out    = wdata_q;
   assign bus.swr          = swr_q;
   assign bus.srd          = srd_q;
   assign bus.out_product  = prod_o;
   assign bus.out_ones     = ones_o;
   assign bus.out_timeout  = to_o;
   assign bus.out_mismatch = mm_o;

endmodule

// File: tb/tb_mult_bus_master.sv
// Bench for mult_bus_master: peripheral model on the strobe bus,
// latency/trace/result model per operation, per-cycle output compare.
module tb_mult_bus_master;

   localparam int PM = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mult_bus_master_if bus_if ();

   mult_bus_master #(.POLL_MAX(PM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // peripheral model configuration and logs
   int          s_nbusy = 0;
   int          stat_reads = 0;
   logic [31:0] s_prod = 32'h0;
   logic [23:0] s_ones = 24'd0;
   logic [15:0] wr_a[$];
   logic [31:0] wr_d[$];
   logic [15:0] rd_a[$];

   always @(posedge bus_if.swr) begin
      wr_a.push_back(bus_if.saddress);
      wr_d.push_back(bus_if.sdata_out);
      if (bus_if.saddress == 16'h03A0) stat_reads = 0;
   end

   always @(posedge bus_if.srd) begin
      logic [31:0] junk;
      junk = $urandom;
      rd_a.push_back(bus_if.saddress);
      case (bus_if.saddress)
         16'h03A0: begin
            if (stat_reads < s_nbusy) bus_if.sdata_in = {junk[31:2], 2'b01};
            else                      bus_if.sdata_in = {junk[31:2], 2'b11};
            stat_reads++;
         end
         16'h0390: bus_if.sdata_in = s_prod;
         16'h0398: bus_if.sdata_in = {junk[31:24], s_ones};
         default:  bus_if.sdata_in = junk;
      endcase
   end

   // expected result of the operation in flight
   logic [31:0] exp_prod = 32'h0;
   logic [23:0] exp_ones = 24'd0;
   logic        exp_to = 1'b0;
   logic        exp_mm = 1'b0;

   // per-cycle compare of the result stream and bus hygiene
   always @(negedge clk) begin
      if (!reset) begin
         check("strobe_excl", bus_if.swr & bus_if.srd, 1'b0);
         if (bus_if.out_valid) begin
            check("out_product", bus_if.out_product, exp_prod);
            check("out_ones", bus_if.out_ones, exp_ones);
            check("out_timeout", bus_if.out_timeout, exp_to);
            check("out_mismatch", bus_if.out_mismatch, exp_mm);
            check("resp_in_ready", bus_if.in_ready, 1'b0);
            check("resp_no_strobe", bus_if.swr | bus_if.srd, 1'b0);
            check("resp_busy", bus_if.busy, 1'b1);
         end
      end
   end

   task automatic model(input int nb, input logic [31:0] p,
                        input logic [23:0] o, output int lat,
                        output int reads, output logic to,
                        output logic [31:0] ep, output logic [23:0] eo,
                        output logic mm);
      if (nb > PM) begin
         to = 1'b1; reads = PM + 1; lat = 13 + 4 * PM + 1;
         ep = 32'h0; eo = 24'd0; mm = 1'b0;
      end else begin
         to = 1'b0; reads = nb + 1; lat = 13 + 4 * nb + 8;
         ep = p; eo = o; mm = ($countones(p) != int'(o));
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus_if.in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", bus_if.in_ready, 1'b1);
   endtask

   task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                         input int nb, input logic [31:0] p,
                         input logic [23:0] o, input int stall,
                         input bit junk, input int lit_lat,
                         input int lit_mm);
      int lat, reads, cyc, bad;
      logic to, mm;
      logic [31:0] ep;
      logic [23:0] eo;
      model(nb, p, o, lat, reads, to, ep, eo, mm);
      s_nbusy = nb; s_prod = p; s_ones = o;
      exp_prod = ep; exp_ones = eo; exp_to = to; exp_mm = mm;
      wr_a.delete(); wr_d.delete(); rd_a.delete();
      wait_ready();
      bus_if.in_valid = 1'b1;
      bus_if.in_a = a;
      bus_if.in_b = b;
      @(posedge clk);
      #1;
      bus_if.in_valid = junk;
      bus_if.in_a = 24'($urandom);
      bus_if.in_b = 24'($urandom);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus_if.out_valid && cyc < 300);
      bus_if.in_valid = 1'b0;
      check("latency", cyc, lat);
      if (lit_lat >= 0) check("latency_lit", cyc, lit_lat);
      if (lit_mm >= 0) check("mismatch_lit", bus_if.out_mismatch, lit_mm[0]);
      repeat (stall) @(negedge clk);
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b0;
      @(negedge clk);
      check("post_hs_in_ready", bus_if.in_ready, 1'b1);
      check("post_hs_valid", bus_if.out_valid, 1'b0);
      check("post_hs_busy", bus_if.busy, 1'b0);
      check("wr_count", wr_a.size(), 3);
      if (wr_a.size() == 3) begin
         check("wr_a1", {wr_a[0], wr_d[0]}, {16'h037F, 8'h00, a});
         check("wr_a2", {wr_a[1], wr_d[1]}, {16'h0388, 8'h00, b});
         check("wr_go", {wr_a[2], wr_d[2]}, {16'h03A0, 32'h0});
      end
      check("rd_count", rd_a.size(), to ? reads : reads + 2);
      bad = 0;
      for (int i = 0; i < reads && i < rd_a.size(); i++)
         if (rd_a[i] != 16'h03A0) bad++;
      check("rd_stat_addr", bad, 0);
      if (!to && rd_a.size() == reads + 2) begin
         check("rd_res_addr", rd_a[reads], 16'h0390);
         check("rd_ones_addr", rd_a[reads + 1], 16'h0398);
      end
   endtask

   task automatic reset_state_check(input string tag);
      check({tag, "_in_ready"}, bus_if.in_ready, 1'b0);
      check({tag, "_outs"}, {bus_if.out_valid, bus_if.busy, bus_if.swr,
            bus_if.srd, bus_if.out_timeout, bus_if.out_mismatch}, 6'd0);
      check({tag, "_saddr"}, bus_if.saddress, 16'h0);
      check({tag, "_wdata"}, bus_if.sdata_out, 32'h0);
      check({tag, "_prod"}, bus_if.out_product, 32'h0);
      check({tag, "_ones"}, bus_if.out_ones, 24'h0);
   endtask

   task automatic reset_mid_op();
      int cyc;
      s_nbusy = 0;
      wait_ready();
      bus_if.in_valid = 1'b1;
      bus_if.in_a = 24'd7;
      bus_if.in_b = 24'd9;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(bus_if.swr && bus_if.saddress == 16'h0388) && cyc < 20);
      check("a2_strobe_cycle", cyc, 5);
      #2;
      reset = 1'b1;
      #1;
      check("async_swr_drop", bus_if.swr, 1'b0);
      reset_state_check("mid_rst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rel_in_ready", bus_if.in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] a, b, o;
      logic [47:0] full;
      logic [31:0] p;
      bus_if.in_valid = 1'b0;
      bus_if.in_a = 24'd0;
      bus_if.in_b = 24'd0;
      bus_if.out_ready = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      reset_state_check("reset");
      reset = 1'b0;
      @(negedge clk);
      check("first_in_ready", bus_if.in_ready, 1'b1);

      run_op(24'd3, 24'd5, 1, 32'h0000000F, 24'd4, 0, 0, 25, 0);
      run_op(24'($urandom), 24'($urandom), 0, 32'hFE000001, 24'd8,
             0, 0, 21, 0);
      run_op(24'($urandom), 24'($urandom), 0, 32'h000000FF, 24'd7,
             0, 0, 21, 1);
      run_op(24'($urandom), 24'($urandom), 255, 32'h12345678, 24'd13,
             0, 0, 30, 0);
      run_op(24'($urandom), 24'($urandom), 2, 32'hDEADBEEF, 24'd24,
             10, 1, 29, 0);
      reset_mid_op();
      run_op(24'd2, 24'd2, 0, 32'h00000004, 24'd1, 0, 0, 21, 0);

      for (int i = 0; i < 30; i++) begin
         a = 24'($urandom);
         b = 24'($urandom);
         full = a * b;
         p = $urandom_range(0, 1) ? full[31:0] : $urandom;
         o = $urandom_range(0, 1) ? 24'($countones(p))
                                  : 24'($urandom_range(0, 32));
         run_op(a, b, $urandom_range(0, 6), p, o, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
